// File: rtl/obi_sram_pkg.sv
// Shared types and constants for the OBI scratchpad slave.
// With OBI_SRAM_OOR_CHECK_EN defined, out-of-range accesses are trapped in obi_sram_slave.
package obi_sram_pkg;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_t;

  localparam logic [31:0] OOR_RDATA = 32'hBADCAB1E;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rsp_beat_t;

  // Merge write data into an existing word under byte enables.
  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/obi_rsp_pipe.sv
// Fixed-depth response shift register; one beat enters and one leaves every cycle.
module obi_rsp_pipe
  import obi_sram_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  rsp_beat_t beat_i,
  output rsp_beat_t beat_o
);

  rsp_beat_t [Depth-1:0] stage_q;
  rsp_beat_t [Depth-1:0] stage_d;

  always_comb begin
    stage_d[0] = beat_i;
    for (int i = 1; i < int'(Depth); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign beat_o = stage_q[Depth-1];

endmodule

// File: rtl/obi_sram_slave.sv
// OBI slave fronting a word-organised scratchpad that zero-fills itself after reset/clear.
// Define OBI_SRAM_OOR_CHECK_EN to trap accesses above the memory's address range.
module obi_sram_slave
  import obi_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        init_done_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_wr;

  logic [31:0]   mem_q [NUM_WORDS];

  logic [AW-1:0] idx;
  logic          oor;
  logic          wr_en;
  rsp_beat_t     rsp_in;
  rsp_beat_t     rsp_out;

  assign idx = addr_i[AW+1:2];

`ifdef OBI_SRAM_OOR_CHECK_EN
  assign oor = |addr_i[31:AW+2];
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];
`else
  assign oor = 1'b0;
  // Upper bits alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    unique case (state_q)
      StInit: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StInit;
      end
    endcase
    // Clear restarts the zero fill from word 0 regardless of current state.
    if (clear_i) begin
      state_d = StInit;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = req_i & (state_q == StReady) & ~clear_i;
  assign init_done_o = (state_q == StReady);
  assign wr_en       = gnt_o & we_i & ~oor;

  // Storage is not reset; the init sequence provides the defined contents.
  always_ff @(posedge clk_i) begin
    if (init_wr) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= apply_be(mem_q[idx], wdata_i, be_i);
    end
  end

  // Read data is sampled before the same-edge write takes effect.
  always_comb begin
    rsp_in.valid = gnt_o;
    rsp_in.data  = '0;
    if (gnt_o && !we_i) begin
      rsp_in.data = oor ? OOR_RDATA : mem_q[idx];
    end
  end

  obi_rsp_pipe #(
    .Depth (LATENCY)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .beat_i (rsp_in),
    .beat_o (rsp_out)
  );

  assign rvalid_o = rsp_out.valid;
  assign rdata_o  = rsp_out.data;

endmodule

// File: tb/tb_obi_sram_slave.sv
// Directed self-checking bench for obi_sram_slave (NUM_WORDS=1024, LATENCY=3).
module tb_obi_sram_slave;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_sram_slave #(
    .NUM_WORDS (1024),
    .LATENCY   (L)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .init_done_o (init_done)
  );

  // Single granted access; checks grant, the quiet cycles, and the response beat.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [31:0] exp, input string nm);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      failures++; $display("FAIL %s_gnt: got %b want 1", nm, gnt);
    end
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0;
    for (int k = 1; k < L; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
        failures++; $display("FAIL %s_early: rvalid got %b want 0 at +%0d", nm, rvalid, k);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp) begin
      failures++;
      $display("FAIL %s_rsp: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", nm, rvalid, rdata, exp);
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0; clear = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL rst_init_done: got %b want 0", init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (gnt === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 1024) begin failures++; $display("FAIL init_len: got %0d want 1024", cyc); end
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("FAIL init_done_up: got %b want 1", init_done);
    end
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL first_rsp: got rvalid=%b rdata=%h want 1/0", rvalid, rdata);
    end
  endtask

  task automatic test_read_zero();
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 32'h0, "rd_init");
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'b0101; wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt: got %b want 1", gnt); end
    @(negedge clk);
    we = 1'b0; be = 4'h0;
    #1;
    checks++;
    if (gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt: got %b want 1", gnt); end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL wr_early: got %b want 0", rvalid); end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL wr_rsp: got %b/%h want 1/00000000", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h00AD00EF) begin
      failures++; $display("FAIL rd_after_wr: got %b/%h want 1/00ad00ef", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++; $display("FAIL idle_rsp: got %b/%h want 0/00000000", rvalid, rdata);
    end
    do_access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, "wr_noop");
    do_access(1'b0, 32'h20, 4'h0, 32'h0, 32'h00AD00EF, "rd_noop");
    do_access(1'b1, 32'h23, 4'b1010, 32'h11223344, 32'h0, "wr_hi");
    do_access(1'b0, 32'h21, 4'h0, 32'h0, 32'h11AD33EF, "rd_hi");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_access(1'b1, 32'(4 * i), 4'hF, 32'(i + 1), 32'h0, "b2b_pre");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (i >= 3 && i <= 8) begin
        if (rvalid !== 1'b1 || rdata !== 32'(i - 2)) begin
          failures++;
          $display("FAIL b2b_rsp%0d: got %b/%h want 1/%h", i, rvalid, rdata, 32'(i - 2));
        end
      end else if (rvalid !== 1'b0) begin
        failures++; $display("FAIL b2b_gap%0d: got %b want 0", i, rvalid);
      end
      if (i < 6) begin
        req = 1'b1; we = 1'b0; addr = 32'(4 * i);
        #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d: got %b want 1", i, gnt); end
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic test_clear();
    do_access(1'b1, 32'h40, 4'hF, 32'h000000A1, 32'h0, "clr_pre0");
    do_access(1'b1, 32'h44, 4'hF, 32'h000000B2, 32'h0, "clr_pre1");
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40;
    @(negedge clk);
    addr = 32'h44;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("FAIL clr_pre_done: got %b want 1", init_done);
    end
    clear = 1'b1; addr = 32'h48;
    #1;
    checks++;
    if (gnt !== 1'b0) begin failures++; $display("FAIL clr_gnt: got %b want 0", gnt); end
    @(negedge clk);
    clear = 1'b0; req = 1'b0;
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL clr_done_fall: got %b want 0", init_done);
    end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA1) begin
      failures++; $display("FAIL clr_rsp0: got %b/%h want 1/000000a1", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hB2) begin
      failures++; $display("FAIL clr_rsp1: got %b/%h want 1/000000b2", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL clr_no_rsp: got %b want 0", rvalid); end
    for (int k = 0; k < 2000; k++) begin
      if (init_done === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("FAIL clr_reinit: got %b want 1", init_done);
    end
    do_access(1'b0, 32'h40, 4'h0, 32'h0, 32'h0, "clr_rd0");
    do_access(1'b0, 32'h44, 4'h0, 32'h0, 32'h0, "clr_rd1");
  endtask

  task automatic test_upper_addr();
`ifdef OBI_SRAM_OOR_CHECK_EN
    do_access(1'b0, 32'h1000, 4'h0, 32'h0, 32'hBADCAB1E, "oor_rd");
    do_access(1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, "oor_wr");
    do_access(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, "oor_mem0");
`else
    do_access(1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, "alias_wr");
    do_access(1'b0, 32'h0, 4'h0, 32'h0, 32'h12345678, "alias_rd");
`endif
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 1'b0 || init_done !== 1'b0) begin
      failures++; $display("FAIL flush_state: got gnt=%b done=%b want 0/0", gnt, init_done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++; $display("FAIL flush_rsp: got %b/%h want 0/00000000", rvalid, rdata);
    end
    req = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_upper_addr();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
